breath_pwm_multi: RTL and testbench

- Multi-channel breathing-LED PWM generator and the parametrised successor of the single-channel breather.
- One shared period counter drives CH independent duty ramps. Each ramp runs a rise / hold-high / fall / hold-low state machine.
- Channels start phase-staggered, so a row of LEDs breathes as a travelling wave.
- Sits between the board-level clock/reset and the LED pins; configured only by parameters plus a few static control inputs.

---
 rtl/breath_pkg.sv | 24 ++
 rtl/breath_ch.sv | 159 +++++++++++++++
 rtl/breath_pwm_multi.sv | 107 ++++++++++
 tb/tb_breath_pwm_multi.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/breath_pkg.sv
// breath_pkg: shared types and elaboration-time helpers for the breathing PWM.
//   breath_state_t : ramp phase of one channel
//   phase_step()   : duty offset between neighbouring channels at reset
//   off_level()    : pin level of an unlit LED for a given polarity
package breath_pkg;

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } breath_state_t;

  // Rounded down to a whole number of STEPs so every channel starts on a
  // duty value that the ramp itself would visit.
  function automatic int phase_step(input int duty_max, input int step, input int ch);
    return (duty_max / step / ch) * step;
  endfunction

  function automatic logic off_level(input int led_active_low);
    return (led_active_low != 32'sd0);
  endfunction

endpackage

// File: rtl/breath_ch.sv
// breath_ch: one breathing channel -- ramp FSM, duty register, hold counter
// and (with BREATH_GAMMA_EN defined) a gamma-corrected compare register.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   advance   : one-cycle strobe on the last cycle of an unpaused frame
//   cmp_load  : (BREATH_GAMMA_EN only) cycle after frame_tick, reload compare
//   cmp       : compare value for the PWM comparator
//   dir       : 1 = rising or hold-low, 0 = falling or hold-high (registered)
module breath_ch
  import breath_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int STEP        = 25,
  parameter int DUTY_MAX    = 5000,
  parameter int HOLD_FRAMES = 0,
  parameter int INIT_DUTY   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
`ifdef BREATH_GAMMA_EN
  input  logic             cmp_load,
`endif
  output logic [CNT_W-1:0] cmp,
  output logic             dir
);

  localparam int HOLD_W = (HOLD_FRAMES > 32'sd1) ? $clog2(HOLD_FRAMES) : 32'sd1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 32'sd1);
  localparam logic [CNT_W:0]    STEP_X    = (CNT_W + 1)'(STEP);
  localparam logic [CNT_W:0]    DMAX_X    = (CNT_W + 1)'(DUTY_MAX);
  localparam logic [CNT_W-1:0]  STEP_N    = CNT_W'(STEP);
  localparam logic [CNT_W-1:0]  DMAX_N    = CNT_W'(DUTY_MAX);
  localparam logic [CNT_W-1:0]  INIT_N    = CNT_W'(INIT_DUTY);

  breath_state_t     state_r, state_n_s;
  logic [CNT_W-1:0]  duty_r, duty_n_s;
  logic [HOLD_W-1:0] hold_r, hold_n_s;
  logic              dir_r, dir_n_s;
  logic [CNT_W:0]    duty_x_s, up_s;
  logic [CNT_W-1:0]  dn_s;

  // One extra bit on the rising sum so the clamp test can never wrap.
  assign duty_x_s = {1'b0, duty_r};
  assign up_s     = duty_x_s + STEP_X;
  assign dn_s     = duty_r - STEP_N;

  // Ramp FSM next state, duty and hold counter; only moves on advance.
  always_comb begin
    state_n_s = state_r;
    duty_n_s  = duty_r;
    hold_n_s  = hold_r;
    if (advance) begin
      case (state_r)
        RISE: begin
          if (up_s >= DMAX_X) begin
            duty_n_s = DMAX_N;
            if (HOLD_FRAMES == 32'sd0) begin
              state_n_s = FALL;
            end else begin
              state_n_s = HOLD_HI;
            end
          end else begin
            duty_n_s = up_s[CNT_W-1:0];
          end
        end
        HOLD_HI: begin
          if (hold_r == HOLD_LAST) begin
            hold_n_s  = {HOLD_W{1'b0}};
            duty_n_s  = dn_s;
            state_n_s = FALL;
          end else begin
            hold_n_s = hold_r + 1'b1;
          end
        end
        FALL: begin
          // duty <= STEP lands exactly on zero instead of underflowing.
          if (duty_x_s <= STEP_X) begin
            duty_n_s = {CNT_W{1'b0}};
            if (HOLD_FRAMES == 32'sd0) begin
              state_n_s = RISE;
            end else begin
              state_n_s = HOLD_LO;
            end
          end else begin
            duty_n_s = dn_s;
          end
        end
        HOLD_LO: begin
          if (hold_r == HOLD_LAST) begin
            hold_n_s  = {HOLD_W{1'b0}};
            duty_n_s  = up_s[CNT_W-1:0];
            state_n_s = RISE;
          end else begin
            hold_n_s = hold_r + 1'b1;
          end
        end
        default: begin
          state_n_s = RISE;
          duty_n_s  = {CNT_W{1'b0}};
          hold_n_s  = {HOLD_W{1'b0}};
        end
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // Direction follows the state being entered so it lines up with duty.
  always_comb begin
    dir_n_s = 1'b1;
    case (state_n_s)
      RISE, HOLD_LO: dir_n_s = 1'b1;
      HOLD_HI, FALL: dir_n_s = 1'b0;
      default:       dir_n_s = 1'b1;
    endcase
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RISE;
      duty_r  <= INIT_N;
      hold_r  <= {HOLD_W{1'b0}};
      dir_r   <= 1'b1;
    end else begin
      state_r <= state_n_s;
      duty_r  <= duty_n_s;
      hold_r  <= hold_n_s;
      dir_r   <= dir_n_s;
    end
  end

  assign dir = dir_r;

`ifdef BREATH_GAMMA_EN
  localparam int DW = $clog2(DUTY_MAX + 32'sd1);
  logic [2*CNT_W-1:0] sq_s;
  logic [CNT_W-1:0]   cmp_r;

  assign sq_s = {{CNT_W{1'b0}}, duty_r} * {{CNT_W{1'b0}}, duty_r};

  // Gamma compare register, reloaded once per frame so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_r <= {CNT_W{1'b0}};
    end else if (cmp_load) begin
      cmp_r <= CNT_W'(sq_s >> DW);
    end else begin
      cmp_r <= cmp_r;
    end
  end

  assign cmp = cmp_r;
`else
  assign cmp = duty_r;
`endif

endmodule

// File: rtl/breath_pwm_multi.sv
// breath_pwm_multi: CH-channel breathing-LED PWM with one shared frame counter
// and phase-staggered ramps (travelling wave across the LED row).
// Optional feature: define BREATH_GAMMA_EN for squared (gamma) brightness.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : global enable; low forces cnt to 0 and all LEDs off
//   pause      : freeze all ramps, PWM keeps running
//   ch_en[CH]  : per-channel output gate (ramp keeps running when gated)
//   led[CH]    : registered PWM pins, polarity set by LED_ACTIVE_LOW
//   dir[CH]    : per-channel ramp direction
//   frame_tick : one-cycle pulse on the last cycle of each frame
module breath_pwm_multi
  import breath_pkg::*;
#(
  parameter int CH             = 4,
  parameter int CNT_W          = 16,
  parameter int PERIOD         = 50000,
  parameter int STEP           = 25,
  parameter int DUTY_MAX       = 5000,
  parameter int HOLD_FRAMES    = 0,
  parameter int LED_ACTIVE_LOW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pause,
  input  logic [CH-1:0] ch_en,
  output logic [CH-1:0] led,
  output logic [CH-1:0] dir,
  output logic          frame_tick
);

  localparam int               PHASE   = phase_step(DUTY_MAX, STEP, CH);
  localparam logic             OFF_LVL = off_level(LED_ACTIVE_LOW);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(PERIOD - 32'sd1);

  logic [CNT_W-1:0] cnt_r, cnt_n_s;
  logic             frame_tick_r;
  logic [CH-1:0]    led_r, lit_s;
  logic             advance_s;
  logic [CNT_W-1:0] cmp_s [CH];

  // Frame counter next value; disabled means parked at zero.
  always_comb begin
    cnt_n_s = {CNT_W{1'b0}};
    if (!en) begin
      cnt_n_s = {CNT_W{1'b0}};
    end else if (cnt_r == LAST) begin
      cnt_n_s = {CNT_W{1'b0}};
    end else begin
      cnt_n_s = cnt_r + 1'b1;
    end
  end

  assign advance_s = en && !pause && (cnt_r == LAST);

  // Counter, frame tick (high while cnt holds LAST) and LED pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= {CNT_W{1'b0}};
      frame_tick_r <= 1'b0;
      led_r        <= {CH{OFF_LVL}};
    end else begin
      cnt_r        <= cnt_n_s;
      frame_tick_r <= en && (cnt_n_s == LAST);
      led_r        <= {CH{OFF_LVL}} ^ (en ? lit_s : {CH{1'b0}});
    end
  end

`ifdef BREATH_GAMMA_EN
  logic cmp_load_r;

  // Delayed tick: channels reload their gamma compare on the first frame cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_load_r <= 1'b0;
    end else begin
      cmp_load_r <= frame_tick_r;
    end
  end
`endif

  for (genvar g = 0; g < CH; g++) begin : g_ch
    breath_ch #(
      .CNT_W      (CNT_W),
      .STEP       (STEP),
      .DUTY_MAX   (DUTY_MAX),
      .HOLD_FRAMES(HOLD_FRAMES),
      .INIT_DUTY  (g * PHASE)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .advance (advance_s),
`ifdef BREATH_GAMMA_EN
      .cmp_load(cmp_load_r),
`endif
      .cmp     (cmp_s[g]),
      .dir     (dir[g])
    );

    assign lit_s[g] = ch_en[g] && (cnt_r < cmp_s[g]);
  end

  assign led        = led_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_breath_pwm_multi.sv
`timescale 1ns/1ps
// Bench for breath_pwm_multi. Two instances share stimulus:
//   A: STEP=10, HOLD_FRAMES=2 (hold path, phase-staggered start)
//   B: STEP=15, HOLD_FRAMES=0 (clamp at peak and zero, no hold)
// The reference describes each ramp as one repeating list of per-frame duty
// values (rise segment, peak run, fall segment, zero run) indexed by the
// number of frames the ramp has been allowed to advance.
module tb_breath_pwm_multi;

  localparam int CH       = 4;
  localparam int CNT_W    = 16;
  localparam int PERIOD   = 100;
  localparam int DUTY_MAX = 50;
  localparam int STEP_A   = 10;
  localparam int HOLD_A   = 2;
  localparam int STEP_B   = 15;
  localparam int HOLD_B   = 0;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          pause;
  logic [CH-1:0] ch_en;
  logic [CH-1:0] led_a, led_b, dir_a, dir_b;
  logic          tick_a, tick_b;

  int n_checks = 0;
  int n_pass   = 0;

  // reference state
  int            m_cnt;
  bit            m_tick;
  int            m_adv;
  logic [CH-1:0] m_led_a, m_led_b;

  // per-frame measurements
  int            meas_a [CH];
  int            meas_b [CH];
  int            meas_ticks;
  logic [CH-1:0] meas_dir_a, meas_dir_b;

  always #5 clk = ~clk;

  breath_pwm_multi #(.CH(CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .STEP(STEP_A),
                     .DUTY_MAX(DUTY_MAX), .HOLD_FRAMES(HOLD_A), .LED_ACTIVE_LOW(1))
  u_dut_a (.clk(clk), .rst(rst), .en(en), .pause(pause), .ch_en(ch_en),
           .led(led_a), .dir(dir_a), .frame_tick(tick_a));

  breath_pwm_multi #(.CH(CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .STEP(STEP_B),
                     .DUTY_MAX(DUTY_MAX), .HOLD_FRAMES(HOLD_B), .LED_ACTIVE_LOW(1))
  u_dut_b (.clk(clk), .rst(rst), .en(en), .pause(pause), .ch_en(ch_en),
           .led(led_b), .dir(dir_b), .frame_tick(tick_b));

  // ---------------- reference model ----------------
  function automatic int seg_len(input int step);
    return (DUTY_MAX - 1) / step;
  endfunction

  function automatic int run_len(input int hold);
    return (hold == 0) ? 1 : hold;
  endfunction

  function automatic int cyc_len(input int step, input int hold);
    return 2 * seg_len(step) + 2 * run_len(hold);
  endfunction

  function automatic int pos_of(input int step, input int hold, input int c, input int adv);
    int d0, start;
    d0 = c * ((DUTY_MAX / step / CH) * step);
    start = (d0 == 0) ? cyc_len(step, hold) - 1 : d0 / step - 1;
    return (start + adv) % cyc_len(step, hold);
  endfunction

  function automatic int exp_duty(input int step, input int hold, input int c, input int adv);
    int p, nr, nh;
    p  = pos_of(step, hold, c, adv);
    nr = seg_len(step);
    nh = run_len(hold);
    if (p < nr)               return (p + 1) * step;
    else if (p < nr + nh)     return DUTY_MAX;
    else if (p < 2 * nr + nh) return DUTY_MAX - (p - nr - nh + 1) * step;
    else                      return 0;
  endfunction

  function automatic bit exp_dir(input int step, input int hold, input int c, input int adv);
    int p, nr, nh;
    p  = pos_of(step, hold, c, adv);
    nr = seg_len(step);
    nh = run_len(hold);
    if (p < nr)               return 1'b1;
    else if (p < 2 * nr + nh) return 1'b0;
    else                      return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   <= 0;
      m_tick  <= 1'b0;
      m_adv   <= 0;
      m_led_a <= '1;
      m_led_b <= '1;
    end else begin
      for (int c = 0; c < CH; c++) begin
        m_led_a[c] <= !(en && ch_en[c] && (m_cnt < exp_duty(STEP_A, HOLD_A, c, m_adv)));
        m_led_b[c] <= !(en && ch_en[c] && (m_cnt < exp_duty(STEP_B, HOLD_B, c, m_adv)));
      end
      if (en && !pause && m_cnt == PERIOD - 1) m_adv <= m_adv + 1;
      m_cnt  <= (en && m_cnt != PERIOD - 1) ? m_cnt + 1 : 0;
      m_tick <= en && (m_cnt == PERIOD - 2);
    end
  end

  // Measures one frame; must be entered at the negedge where frame_tick is high.
  task automatic measure_frame();
    for (int c = 0; c < CH; c++) begin
      meas_a[c] = 0;
      meas_b[c] = 0;
    end
    meas_ticks = 0;
    for (int k = 0; k < PERIOD; k++) begin
      @(negedge clk);
      if (k == 0) begin
        meas_dir_a = dir_a;
        meas_dir_b = dir_b;
      end
      for (int c = 0; c < CH; c++) begin
        if (led_a[c] == 1'b0) meas_a[c]++;
        if (led_b[c] == 1'b0) meas_b[c]++;
      end
      if (tick_a) meas_ticks++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; en = 1'b1; pause = 1'b0; ch_en = '1;
    repeat (3) @(negedge clk);
    n_checks++; if (led_a !== 4'hF) $display("FAIL reset_led_a: got %h want f", led_a); else n_pass++;
    n_checks++; if (led_b !== 4'hF) $display("FAIL reset_led_b: got %h want f", led_b); else n_pass++;
    n_checks++; if (dir_a !== 4'hF) $display("FAIL reset_dir_a: got %h want f", dir_a); else n_pass++;
    n_checks++; if (tick_a !== 1'b0) $display("FAIL reset_tick: got %b want 0", tick_a); else n_pass++;
  endtask

  task automatic test_first_frame();
    int first_tick, lo1_first, lo1_last;
    int lit [CH];
    int exp_w [CH];
    exp_w = '{0, 10, 20, 30};
    first_tick = -1; lo1_first = -1; lo1_last = -1;
    for (int c = 0; c < CH; c++) lit[c] = 0;
    rst = 1'b0;
    for (int n = 1; n < PERIOD; n++) begin
      @(negedge clk);
      if (tick_a && first_tick < 0) first_tick = n;
      for (int c = 0; c < CH; c++) if (led_a[c] == 1'b0) lit[c]++;
      if (led_a[1] == 1'b0) begin
        if (lo1_first < 0) lo1_first = n;
        lo1_last = n;
      end
    end
    n_checks++; if (first_tick != 99) $display("FAIL first_tick_cycle: got %0d want 99", first_tick); else n_pass++;
    n_checks++; if (lo1_first != 1 || lo1_last != 10)
      $display("FAIL led1_window: got %0d..%0d want 1..10", lo1_first, lo1_last); else n_pass++;
    for (int c = 0; c < CH; c++) begin
      n_checks++; if (lit[c] != exp_w[c]) $display("FAIL init_width ch%0d: got %0d want %0d", c, lit[c], exp_w[c]); else n_pass++;
    end
  endtask

  task automatic test_ramp();
    int seq_a [13];
    int seq_b [13];
    bit dsq_a [13];
    bit dsq_b [13];
    seq_a = '{10, 20, 30, 40, 50, 50, 40, 30, 20, 10, 0, 0, 10};
    dsq_a = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    seq_b = '{15, 30, 45, 50, 35, 20, 5, 0, 15, 30, 45, 50, 35};
    dsq_b = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    for (int k = 0; k < 13; k++) begin
      measure_frame();
      n_checks++; if (meas_a[0] != seq_a[k]) $display("FAIL ramp_a tick%0d: got %0d want %0d", k + 1, meas_a[0], seq_a[k]); else n_pass++;
      n_checks++; if (meas_b[0] != seq_b[k]) $display("FAIL clamp_b tick%0d: got %0d want %0d", k + 1, meas_b[0], seq_b[k]); else n_pass++;
      n_checks++; if (meas_dir_a[0] !== dsq_a[k]) $display("FAIL dir_a tick%0d: got %b want %b", k + 1, meas_dir_a[0], dsq_a[k]); else n_pass++;
      n_checks++; if (meas_dir_b[0] !== dsq_b[k]) $display("FAIL dir_b tick%0d: got %b want %b", k + 1, meas_dir_b[0], dsq_b[k]); else n_pass++;
      n_checks++; if (meas_ticks != 1) $display("FAIL ticks_per_frame: got %0d want 1", meas_ticks); else n_pass++;
    end
  endtask

  task automatic test_pause();
    int w [CH];
    measure_frame();
    for (int c = 0; c < CH; c++) w[c] = meas_a[c];
    pause = 1'b1;
    for (int f = 0; f < 3; f++) begin
      measure_frame();
      for (int c = 0; c < CH; c++) begin
        n_checks++; if (meas_a[c] != w[c]) $display("FAIL pause_frozen ch%0d: got %0d want %0d", c, meas_a[c], w[c]); else n_pass++;
      end
      n_checks++; if (meas_ticks != 1) $display("FAIL pause_tick: got %0d want 1", meas_ticks); else n_pass++;
    end
    pause = 1'b0;
    measure_frame();
    for (int c = 0; c < CH; c++) begin
      n_checks++;
      if (meas_a[c] != exp_duty(STEP_A, HOLD_A, c, m_adv))
        $display("FAIL pause_resume ch%0d: got %0d want %0d", c, meas_a[c], exp_duty(STEP_A, HOLD_A, c, m_adv));
      else n_pass++;
    end
  endtask

  task automatic test_enable();
    int n_found;
    ch_en = 4'b1011;
    measure_frame();
    n_checks++; if (meas_a[2] != 0) $display("FAIL ch_en_gated_a: got %0d want 0", meas_a[2]); else n_pass++;
    n_checks++; if (meas_b[2] != 0) $display("FAIL ch_en_gated_b: got %0d want 0", meas_b[2]); else n_pass++;
    ch_en = 4'hF;
    measure_frame();
    n_checks++;
    if (meas_a[2] != exp_duty(STEP_A, HOLD_A, 2, m_adv))
      $display("FAIL ch_en_ramp_kept: got %0d want %0d", meas_a[2], exp_duty(STEP_A, HOLD_A, 2, m_adv));
    else n_pass++;
    // drop en in the middle of a frame
    repeat (30) @(negedge clk);
    en = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      n_checks++; if (led_a !== 4'hF || led_b !== 4'hF) $display("FAIL en_off_led: got %h/%h want f/f", led_a, led_b); else n_pass++;
      n_checks++; if (tick_a !== 1'b0) $display("FAIL en_off_tick: got %b want 0", tick_a); else n_pass++;
    end
    en = 1'b1;
    n_found = -1;
    for (int n = 1; n <= 2 * PERIOD; n++) begin
      @(negedge clk);
      if (tick_a) begin
        n_found = n;
        break;
      end
    end
    n_checks++; if (n_found != 99) $display("FAIL en_restart_tick: got %0d want 99", n_found); else n_pass++;
  endtask

  task automatic test_async_reset();
    repeat ($urandom_range(10, 80)) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (led_a !== 4'hF || led_b !== 4'hF) $display("FAIL async_led: got %h/%h want f/f", led_a, led_b); else n_pass++;
    n_checks++; if (dir_a !== 4'hF || dir_b !== 4'hF) $display("FAIL async_dir: got %h/%h want f/f", dir_a, dir_b); else n_pass++;
    n_checks++; if (tick_a !== 1'b0) $display("FAIL async_tick: got %b want 0", tick_a); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [CH-1:0] ed_a, ed_b;
    int errs;
    errs = 0;
    for (int n = 0; n < 6000; n++) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        ed_a[c] = exp_dir(STEP_A, HOLD_A, c, m_adv);
        ed_b[c] = exp_dir(STEP_B, HOLD_B, c, m_adv);
      end
      n_checks++;
      if (led_a !== m_led_a || led_b !== m_led_b || tick_a !== m_tick || tick_b !== m_tick ||
          dir_a !== ed_a || dir_b !== ed_b) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random cyc%0d: led %h/%h dir %h/%h tick %b/%b want led %h/%h dir %h/%h tick %b",
                   n, led_a, led_b, dir_a, dir_b, tick_a, tick_b, m_led_a, m_led_b, ed_a, ed_b, m_tick);
      end else n_pass++;
      if (en) begin
        if ($urandom_range(0, 599) == 0) en = 1'b0;
      end else begin
        if ($urandom_range(0, 49) == 0) en = 1'b1;
      end
      if ($urandom_range(0, 299) == 0) pause = ~pause;
      if ($urandom_range(0, 199) == 0) ch_en = CH'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_ramp();
    test_pause();
    test_enable();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
